// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED-matrix scan controller: fetches top/bottom pixel pairs, shifts one bit plane per
// row into the panel, then latches and displays it for a binary-weighted time (BCM).
module hub75_scan_ctrl #(
  parameter int unsigned COLS      = 64,
  parameter int unsigned ROWS_HALF = 16,
  parameter int unsigned BPP       = 4,
  parameter int unsigned BASE_TIME = 8,
  localparam int unsigned ROW_W    = $clog2(ROWS_HALF),
  localparam int unsigned COL_W    = $clog2(COLS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  output logic [COL_W-1:0] o_rd_col,
  output logic [ROW_W-1:0] o_rd_row,
  input  logic [3*BPP-1:0] i_pix_top,
  input  logic [3*BPP-1:0] i_pix_bot,
  output logic [1:0]       o_data_r,
  output logic [1:0]       o_data_g,
  output logic [1:0]       o_data_b,
  output logic             o_clk,
  output logic             o_latch,
  output logic             o_blank,
  output logic [ROW_W-1:0] o_row_addr,
  output logic             o_frame_done
);

  localparam int unsigned SH_W    = COL_W + 1;
  localparam int unsigned PLANE_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int unsigned DISP_W  = $clog2((BASE_TIME << (BPP - 1)) + 1);

  typedef enum logic [2:0] {
    StIdle,
    StPrefetch,
    StShift,
    StBlank,
    StLatch,
    StDisplay
  } state_e;

  state_e              state_q, state_d;
  logic [SH_W-1:0]     shift_cnt_q, shift_cnt_d;
  logic [DISP_W-1:0]   disp_cnt_q, disp_cnt_d;
  logic [PLANE_W-1:0]  plane_q, plane_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ROW_W-1:0]    row_addr_q, row_addr_d;
  logic [5:0]          data_q, data_d;

  logic [BPP-1:0]      top_r, top_g, top_b, bot_r, bot_g, bot_b;
  logic [5:0]          pix_bits;
  logic [DISP_W-1:0]   disp_len;
  logic                shift_last, disp_last, plane_last, row_last;

  assign top_r = i_pix_top[3*BPP-1:2*BPP];
  assign top_g = i_pix_top[2*BPP-1:BPP];
  assign top_b = i_pix_top[BPP-1:0];
  assign bot_r = i_pix_bot[3*BPP-1:2*BPP];
  assign bot_g = i_pix_bot[2*BPP-1:BPP];
  assign bot_b = i_pix_bot[BPP-1:0];

  // Packed as {r[bot,top], g[bot,top], b[bot,top]} for the current plane.
  assign pix_bits = {bot_r[plane_q], top_r[plane_q], bot_g[plane_q], top_g[plane_q],
                     bot_b[plane_q], top_b[plane_q]};

  assign disp_len   = DISP_W'(BASE_TIME) << plane_q;
  assign shift_last = (shift_cnt_q == SH_W'(2 * COLS - 1));
  assign disp_last  = (disp_cnt_q == disp_len - DISP_W'(1));
  assign plane_last = (plane_q == PLANE_W'(BPP - 1));
  assign row_last   = (row_q == ROW_W'(ROWS_HALF - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      shift_cnt_q <= '0;
      disp_cnt_q  <= '0;
      plane_q     <= '0;
      row_q       <= '0;
      row_addr_q  <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      disp_cnt_q  <= disp_cnt_d;
      plane_q     <= plane_d;
      row_q       <= row_d;
      row_addr_q  <= row_addr_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    disp_cnt_d  = disp_cnt_q;
    plane_d     = plane_q;
    row_d       = row_q;
    row_addr_d  = row_addr_q;
    data_d      = data_q;
    unique case (state_q)
      StIdle: begin
        if (i_enable) state_d = StPrefetch;
      end
      StPrefetch: begin
        shift_cnt_d = '0;
        state_d     = StShift;
      end
      StShift: begin
        // Capture on the even cycle so data stays put across the rising o_clk.
        if (!shift_cnt_q[0]) data_d = pix_bits;
        if (shift_last) begin
          state_d = StBlank;
        end else begin
          shift_cnt_d = shift_cnt_q + SH_W'(1);
        end
      end
      StBlank: begin
        // Row select moves while LATCH is still blanked.
        row_addr_d = row_q;
        state_d    = StLatch;
      end
      StLatch: begin
        disp_cnt_d = '0;
        state_d    = StDisplay;
      end
      StDisplay: begin
        if (disp_last) begin
          if (plane_last) begin
            plane_d = '0;
            row_d   = row_last ? '0 : row_q + ROW_W'(1);
          end else begin
            plane_d = plane_q + PLANE_W'(1);
          end
          state_d = i_enable ? StPrefetch : StIdle;
        end else begin
          disp_cnt_d = disp_cnt_q + DISP_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_rd_col     = '0;
    o_rd_row     = row_q;
    o_clk        = 1'b0;
    o_latch      = 1'b0;
    o_blank      = 1'b1;
    o_row_addr   = row_addr_q;
    o_frame_done = 1'b0;
    o_data_r     = '0;
    o_data_g     = '0;
    o_data_b     = '0;
    unique case (state_q)
      StShift: begin
        // Odd cycles already address the next column.
        o_rd_col = shift_cnt_q[SH_W-1:1] + COL_W'(shift_cnt_q[0]);
        o_clk    = shift_cnt_q[0];
        {o_data_r, o_data_g, o_data_b} = shift_cnt_q[0] ? data_q : pix_bits;
      end
      StLatch: o_latch = 1'b1;
      StDisplay: begin
        o_blank      = 1'b0;
        o_frame_done = disp_last && plane_last && row_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl with COLS=4, ROWS_HALF=2, BPP=2, BASE_TIME=3.
module tb_hub75_scan_ctrl;

  localparam int unsigned COLS      = 4;
  localparam int unsigned ROWS_HALF = 2;
  localparam int unsigned BPP       = 2;
  localparam int unsigned BASE_TIME = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] rd_col;
  logic       rd_row;
  logic [5:0] pix_top;
  logic [5:0] pix_bot;
  logic [1:0] dr, dg, db;
  logic       pclk, latch, blank;
  logic       row_addr;
  logic       frame_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_done = 0;
  int done_cyc [4];

  // Expected {r,g,b} data (each {bottom,top}) indexed [plane][column parity].
  // Even columns: top 10_01_11, bottom 01_11_00. Odd columns: top 00_00_00, bottom 11_11_11.
  logic [5:0] exp_data [2][2] = '{'{6'b10_11_01, 6'b10_10_10},
                                  '{6'b01_10_01, 6'b10_10_10}};

  hub75_scan_ctrl #(
    .COLS      (COLS),
    .ROWS_HALF (ROWS_HALF),
    .BPP       (BPP),
    .BASE_TIME (BASE_TIME)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .o_rd_col     (rd_col),
    .o_rd_row     (rd_row),
    .i_pix_top    (pix_top),
    .i_pix_bot    (pix_bot),
    .o_data_r     (dr),
    .o_data_g     (dg),
    .o_data_b     (db),
    .o_clk        (pclk),
    .o_latch      (latch),
    .o_blank      (blank),
    .o_row_addr   (row_addr),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer with one cycle of read latency.
  always @(posedge clk) begin
    pix_top <= rd_col[0] ? 6'b00_00_00 : 6'b10_01_11;
    pix_bot <= rd_col[0] ? 6'b11_11_11 : 6'b01_11_00;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_rd_col", rd_col, 0);
    chk("rst_rd_row", rd_row, 0);
    chk("rst_data", {dr, dg, db}, 0);
    chk("rst_clk", pclk, 0);
    chk("rst_latch", latch, 0);
    chk("rst_blank", blank, 1);
    chk("rst_row_addr", row_addr, 0);
    chk("rst_frame_done", frame_done, 0);
  endtask

  // Called at the negedge before PREFETCH; returns at the negedge of the last DISPLAY cycle
  // (or right after asserting reset at display cycle rst_at).
  task automatic run_plane(input int row, input int plane, input int prev_addr,
                           input int drop_at, input int rst_at);
    int   len;
    int   rises;
    logic prev_clk;
    len = BASE_TIME << plane;
    @(negedge clk);
    chk("pre_rd_col", rd_col, 0);
    chk("pre_rd_row", rd_row, row);
    chk("pre_blank", blank, 1);
    chk("pre_clk", pclk, 0);
    chk("pre_latch", latch, 0);
    rises    = 0;
    prev_clk = 1'b0;
    for (int k = 0; k < 2 * COLS; k++) begin
      @(negedge clk);
      chk("sh_clk", pclk, k % 2);
      chk("sh_rd_col", rd_col, ((k / 2) + (k % 2)) % COLS);
      chk("sh_rd_row", rd_row, row);
      chk("sh_data", {dr, dg, db}, exp_data[plane][(k / 2) % 2]);
      chk("sh_blank", blank, 1);
      chk("sh_latch", latch, 0);
      chk("sh_row_addr", row_addr, prev_addr);
      if (pclk && !prev_clk) rises++;
      prev_clk = pclk;
      if (k == drop_at) en = 1'b0;
    end
    chk("clk_rises", rises, COLS);
    @(negedge clk);
    chk("bl_clk", pclk, 0);
    chk("bl_blank", blank, 1);
    chk("bl_latch", latch, 0);
    chk("bl_row_addr", row_addr, prev_addr);
    @(negedge clk);
    chk("la_latch", latch, 1);
    chk("la_blank", blank, 1);
    chk("la_clk", pclk, 0);
    chk("la_row_addr", row_addr, row);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("dp_blank", blank, 0);
      chk("dp_latch", latch, 0);
      chk("dp_clk", pclk, 0);
      chk("dp_row_addr", row_addr, row);
      chk("dp_frame_done", frame_done, (k == len - 1 && plane == 1 && row == 1) ? 1 : 0);
      if (frame_done === 1'b1 && n_done < 4) begin
        done_cyc[n_done] = cyc;
        n_done++;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();

    // Two full frames with enable held high.
    en  = 1'b1;
    rst = 1'b0;
    run_plane(0, 0, 0, -1, -1);
    run_plane(0, 1, 0, -1, -1);
    run_plane(1, 0, 0, -1, -1);
    run_plane(1, 1, 1, -1, -1);
    run_plane(0, 0, 1, -1, -1);
    run_plane(0, 1, 0, -1, -1);
    run_plane(1, 0, 0, -1, -1);
    run_plane(1, 1, 1, -1, -1);
    chk("frame_done_count", n_done, 2);
    chk("frame_period", done_cyc[1] - done_cyc[0], 62);

    // Drop enable mid-shift: plane finishes, then idles blanked.
    run_plane(0, 0, 1, 3, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_blank", blank, 1);
      chk("idle_clk", pclk, 0);
      chk("idle_latch", latch, 0);
      chk("idle_rd_col", rd_col, 0);
      chk("idle_row_addr", row_addr, 0);
    end
    en = 1'b1;
    run_plane(0, 1, 0, -1, -1);
    run_plane(1, 0, 0, -1, -1);

    // Reset during plane 1 display of row 1, then restart from row 0 plane 0.
    run_plane(1, 1, 1, -1, 2);
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    run_plane(0, 0, 0, -1, -1);
    run_plane(0, 1, 0, -1, -1);
    chk("frame_done_total", n_done, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
